// File: rtl/dev_fifo_read_port_pkg.sv
// Shared I/O device definitions: decode configuration, device-type selector and
// status-byte layout for the FIFO read port.
package MSX;

   typedef struct packed {
      logic       enable;
      logic [7:0] port;
      logic [7:0] mask;
   } io_device_t;

   typedef enum logic [2:0] {
      DEV_NONE,
      DEV_LATCH_PORT,
      DEV_FIFO_READ_PORT
   } device_type_t;

   localparam int unsigned ST_AVAIL  = 7;
   localparam int unsigned ST_FULL   = 6;
   localparam int unsigned ST_OVF    = 5;
   localparam int unsigned ST_CNT_HI = 4;
   localparam int unsigned ST_CNT_LO = 0;

   localparam logic [7:0] IDLE_READ = 8'hFF;

endpackage

// File: rtl/dev_fifo_read_port_byte_fifo.sv
// Byte FIFO with synchronous storage and wrapping pointers. The caller is
// responsible for qualifying push with ~full and pop with ~empty.
module byte_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Storage is deliberately left out of reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/dev_fifo_read_port.sv
// CPU-readable inbound FIFO port: DATA pops bytes pushed by a peripheral producer,
// STATUS reports avail/full/sticky-overflow/count.
module dev_fifo_read_port
   import MSX::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       addr,
   input  logic             iorq,
   input  logic             m1,
   input  logic             rd,
   input  logic             req,
   input  MSX::io_device_t  io_device,
   input  logic             push_valid,
   input  logic [7:0]       push_data,
   output logic             push_ready,
   output logic [7:0]       data_out,
   output logic             data_oe
);

   logic          io_en;
   logic          sel;
   logic          pop;
   logic          push;
   logic          status_strobe;
   logic [7:0]    head;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic [7:0]    status;
   logic          ovf_q, ovf_d;

   assign io_en = iorq && !m1;
   assign sel   = io_device.enable && io_en &&
                  ((addr & io_device.mask & 8'hFE) == (io_device.port & 8'hFE));

   assign data_oe       = sel && rd;
   assign pop           = data_oe && req && !addr[0] && !empty;
   assign status_strobe = data_oe && req && addr[0];

   assign push_ready = !full;
   assign push       = push_valid && !full;

   byte_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      status                      = '0;
      status[ST_AVAIL]            = !empty;
      status[ST_FULL]             = full;
      status[ST_OVF]              = ovf_q;
      status[ST_CNT_HI:ST_CNT_LO] = 5'(count);
   end

   always_comb begin
      data_out = IDLE_READ;
      if (data_oe) begin
         if (addr[0]) begin
            data_out = status;
         end else if (!empty) begin
            data_out = head;
         end
      end
   end

   // A dropped byte in the same cycle as a status read must stay visible.
   always_comb begin
      ovf_d = ovf_q;
      if (push_valid && full) begin
         ovf_d = 1'b1;
      end else if (status_strobe) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: tb/tb_dev_fifo_read_port.sv
// Scoreboard bench for dev_fifo_read_port: stimulus queues expected read data,
// a monitor compares whenever the device drives the bus.
module tb_dev_fifo_read_port;
   import MSX::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] addr;
   logic       iorq, m1, rd, req;
   io_device_t io_device;
   logic       push_valid;
   logic [7:0] push_data;
   logic       push_ready;
   logic [7:0] data_out;
   logic       data_oe;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] expq[$];
   logic [7:0] model[$];

   always #5 clk = ~clk;

   dev_fifo_read_port #(.DEPTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .iorq       (iorq),
      .m1         (m1),
      .rd         (rd),
      .req        (req),
      .io_device  (io_device),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_ready (push_ready),
      .data_out   (data_out),
      .data_oe    (data_oe)
   );

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h, expected %02h", name, got, exp);
   endtask

   // Monitor: every cycle the device drives the bus, consume one expected byte.
   always @(negedge clk) begin
      if (data_oe === 1'b1) begin
         if (expq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_read: got %02h at addr %02h, expected no drive",
                     data_out, addr);
         end else begin
            check("read_data", data_out, expq.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic in_port(input logic [7:0] a, input logic [7:0] exp);
      addr = a; iorq = 1'b1; rd = 1'b1; req = 1'b1; m1 = 1'b0;
      expq.push_back(exp);
      tick();
      iorq = 1'b0; rd = 1'b0; req = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] d);
      push_valid = 1'b1; push_data = d;
      tick();
      push_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; addr = 8'h00; iorq = 1'b0; m1 = 1'b0; rd = 1'b0; req = 1'b0;
      push_valid = 1'b0; push_data = 8'h00;
      io_device = '{enable: 1'b1, port: 8'h40, mask: 8'hFF};
      tick(); tick();
      @(negedge clk);
      check("reset_push_ready", {7'd0, push_ready}, 8'h01);
      check("reset_data_oe", {7'd0, data_oe}, 8'h00);
      check("reset_data_out", data_out, 8'hFF);
      reset = 1'b0;
      tick();

      // Empty FIFO reads
      in_port(8'h41, 8'h00);
      in_port(8'h40, 8'hFF);
      in_port(8'h41, 8'h00);
      @(negedge clk);
      check("empty_push_ready", {7'd0, push_ready}, 8'h01);
      tick();

      // Two bytes
      push_byte(8'hA5);
      push_byte(8'h5A);
      in_port(8'h41, 8'h82);
      in_port(8'h40, 8'hA5);
      in_port(8'h40, 8'h5A);
      in_port(8'h40, 8'hFF);
      in_port(8'h41, 8'h00);

      // Fill, overflow, clear
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      @(negedge clk);
      check("full_push_ready", {7'd0, push_ready}, 8'h00);
      tick();
      in_port(8'h41, 8'hD0);
      push_byte(8'hEE);
      in_port(8'h41, 8'hF0);
      in_port(8'h41, 8'hD0);
      for (int i = 0; i < 16; i++) in_port(8'h40, 8'(i));
      in_port(8'h40, 8'hFF);

      // Full with push attempt and pop in the same cycle
      for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
      push_valid = 1'b1; push_data = 8'h99;
      in_port(8'h40, 8'h20);
      push_valid = 1'b0;
      in_port(8'h41, 8'hAF);
      in_port(8'h41, 8'h8F);
      for (int i = 1; i < 16; i++) in_port(8'h40, 8'h20 + 8'(i));
      in_port(8'h40, 8'hFF);

      // Simultaneous push/pop at count 3, crossing pointer wrap
      model = {};
      for (int i = 1; i <= 3; i++) begin
         push_byte(8'(i));
         model.push_back(8'(i));
      end
      for (int i = 0; i < 20; i++) begin
         push_valid = 1'b1; push_data = 8'h30 + 8'(i);
         model.push_back(8'h30 + 8'(i));
         in_port(8'h40, model.pop_front());
         push_valid = 1'b0;
      end
      in_port(8'h41, 8'h83);
      while (model.size() > 0) in_port(8'h40, model.pop_front());
      in_port(8'h40, 8'hFF);

      // Held read with a single req pulse pops once
      push_byte(8'h77);
      push_byte(8'h88);
      addr = 8'h40; iorq = 1'b1; rd = 1'b1; req = 1'b1;
      expq.push_back(8'h77);
      tick();
      req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expq.push_back(8'h88);
         tick();
      end
      iorq = 1'b0; rd = 1'b0;
      in_port(8'h41, 8'h81);

      // Interrupt acknowledge and disabled device do not decode
      addr = 8'h40; iorq = 1'b1; rd = 1'b1; req = 1'b1; m1 = 1'b1;
      @(negedge clk);
      check("m1_data_oe", {7'd0, data_oe}, 8'h00);
      check("m1_data_out", data_out, 8'hFF);
      tick();
      m1 = 1'b0; io_device.enable = 1'b0;
      @(negedge clk);
      check("dis_data_oe", {7'd0, data_oe}, 8'h00);
      check("dis_data_out", data_out, 8'hFF);
      tick();
      iorq = 1'b0; rd = 1'b0; req = 1'b0; io_device.enable = 1'b1;
      in_port(8'h41, 8'h81);

      // Reset coinciding with a pop
      reset = 1'b1;
      in_port(8'h40, 8'h88);
      reset = 1'b0;
      in_port(8'h41, 8'h00);

      tick(); tick();
      check("scoreboard_drained", 8'(expq.size()), 8'h00);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
